mem_bus_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared external memory bus (ROM + RAM). It sits between the CPU's memory I/O stage and the ram/rom blocks, and lets a host loader port share the bus with the CPU without using the force_* backdoor. Each transaction runs through a fixed IDLE → ACCESS → DONE sequence: round-robin grant, optional host lock, address-region decode, and a saturating CPU stall counter.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_region_decode.sv | 22 ++
 rtl/mem_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_arb_pkg
// Purpose  : Shared types and constants for the memory bus arbiter slice
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_CPU  = 1'b0,
    REQ_HOST = 1'b1
  } requester_t;

  localparam logic [15:0] RAM_BASE_DEFAULT = 16'h8000;

endpackage
`default_nettype wire

// File: rtl/mem_region_decode.sv
`default_nettype none
// ============================================================================
// Module   : mem_region_decode
// Purpose  : Splits the 16-bit address space into ROM (low) and RAM (high)
// Revision : 1.0 - initial release
// ============================================================================
module mem_region_decode
  import mem_arb_pkg::*;
#(
  parameter logic [15:0] RAM_BASE = RAM_BASE_DEFAULT
) (
  input  logic [15:0] addr,
  input  logic        valid,
  output logic        ram_enable,
  output logic        rom_enable
);

  assign ram_enable = valid && (addr >= RAM_BASE);
  assign rom_enable = valid && (addr <  RAM_BASE);

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : CPU/host round-robin arbiter and IDLE->ACCESS->DONE bus sequencer
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter logic [15:0] RAM_BASE      = RAM_BASE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        host_ack,
  input  logic        host_lock,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        wr_en,
  output logic        rd_en,
  output logic        ram_enable,
  output logic        rom_enable,
  output logic [15:0] cpu_wait_count
);

  localparam int unsigned      CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_t       state_q, state_d;
  requester_t       owner_q, owner_d;
  requester_t       last_grant_q, last_grant_d;
  logic             we_q, we_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      wait_q, wait_d;

  logic grant_cpu;
  logic grant_host;
  logic cpu_stalled;
  logic in_access;
  logic in_done;

  // Grant candidates; only acted upon while IDLE.
  always_comb begin
    grant_cpu  = 1'b0;
    grant_host = 1'b0;
    if (host_lock) begin
      grant_host = host_req;
    end else if (cpu_req && host_req) begin
      grant_cpu  = (last_grant_q == REQ_HOST);
      grant_host = (last_grant_q == REQ_CPU);
    end else begin
      grant_cpu  = cpu_req;
      grant_host = host_req;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_cpu) begin
          owner_d      = REQ_CPU;
          last_grant_d = REQ_CPU;
          we_d         = cpu_we;
          addr_d       = cpu_addr;
          wdata_d      = cpu_wdata;
          state_d      = ACCESS;
        end else if (grant_host) begin
          owner_d      = REQ_HOST;
          last_grant_d = REQ_HOST;
          we_d         = host_we;
          addr_d       = host_addr;
          wdata_d      = host_wdata;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d = we_q ? 8'h00 : mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cpu_stalled = cpu_req && ((state_q == IDLE) ? !grant_cpu : (owner_q != REQ_CPU));
    if (cpu_stalled && (wait_q != 16'hFFFF)) begin
      wait_d = wait_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= REQ_CPU;
      last_grant_q <= REQ_HOST;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
    end
  end

  // Every bus-facing output is a decode of registered state only.
  assign in_access   = (state_q == ACCESS);
  assign in_done     = (state_q == DONE);
  assign mem_address = in_access ? addr_q : 16'h0000;
  assign mem_wdata   = (in_access && we_q) ? wdata_q : 8'h00;
  assign wr_en       = in_access && we_q;
  assign rd_en       = in_access && !we_q;

  assign cpu_ack     = in_done && (owner_q == REQ_CPU);
  assign host_ack    = in_done && (owner_q == REQ_HOST);
  assign cpu_rdata   = cpu_ack  ? rdata_q : 8'h00;
  assign host_rdata  = host_ack ? rdata_q : 8'h00;

  assign cpu_wait_count = wait_q;

  mem_region_decode #(
    .RAM_BASE (RAM_BASE)
  ) u_region_decode (
    .addr       (addr_q),
    .valid      (in_access),
    .ram_enable (ram_enable),
    .rom_enable (rom_enable)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed + random bench for two arbiter instances (1 and 3 access cycles)
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [15:0] cpu_addr, host_addr;
  logic [7:0]  cpu_wdata, host_wdata, mem_rdata;

  logic [7:0]  d1_cpu_rdata, d1_host_rdata, d1_mem_wdata;
  logic        d1_cpu_ack, d1_host_ack, d1_wr_en, d1_rd_en, d1_ram_enable, d1_rom_enable;
  logic [15:0] d1_mem_address, d1_cpu_wait_count;
  logic [7:0]  d3_cpu_rdata, d3_host_rdata, d3_mem_wdata;
  logic        d3_cpu_ack, d3_host_ack, d3_wr_en, d3_rd_en, d3_ram_enable, d3_rom_enable;
  logic [15:0] d3_mem_address, d3_cpu_wait_count;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model: a transaction is described by its grant cycle; everything
  // else follows from elapsed time against the access length.
  int          ac [2] = '{1, 3};
  bit          m_busy [2];
  int          m_g [2];
  bit          m_owner [2];
  bit          m_we [2];
  logic [15:0] m_addr [2];
  logic [7:0]  m_wdata [2];
  logic [7:0]  m_rd [2];
  bit          m_last [2];
  int          m_wait [2];

  mem_bus_arbiter #(.ACCESS_CYCLES(1), .RAM_BASE(16'h8000)) u_dut1 (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(d1_cpu_rdata), .cpu_ack(d1_cpu_ack),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(d1_host_rdata), .host_ack(d1_host_ack), .host_lock(host_lock),
    .mem_address(d1_mem_address), .mem_wdata(d1_mem_wdata), .mem_rdata(mem_rdata),
    .wr_en(d1_wr_en), .rd_en(d1_rd_en), .ram_enable(d1_ram_enable), .rom_enable(d1_rom_enable),
    .cpu_wait_count(d1_cpu_wait_count)
  );

  mem_bus_arbiter #(.ACCESS_CYCLES(3), .RAM_BASE(16'h8000)) u_dut3 (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(d3_cpu_rdata), .cpu_ack(d3_cpu_ack),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(d3_host_rdata), .host_ack(d3_host_ack), .host_lock(host_lock),
    .mem_address(d3_mem_address), .mem_wdata(d3_mem_wdata), .mem_rdata(mem_rdata),
    .wr_en(d3_wr_en), .rd_en(d3_rd_en), .ram_enable(d3_ram_enable), .rom_enable(d3_rom_enable),
    .cpu_wait_count(d3_cpu_wait_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_init();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0;
      m_last[i] = 1'b1;
      m_wait[i] = 0;
      m_rd[i]   = 8'h00;
      m_g[i]    = 0;
    end
  endtask

  task automatic check_dut(input int i, input logic [7:0] cr, input logic ca,
                           input logic [7:0] hr, input logic ha, input logic [15:0] ma,
                           input logic [7:0] mw, input logic wr, input logic rd,
                           input logic rame, input logic rome, input logic [15:0] wc);
    bit          acc, ack;
    logic [27:0] e_bus;
    logic [8:0]  e_cpu, e_host;
    acc = m_busy[i] && (cyc > m_g[i]) && (cyc <= m_g[i] + ac[i]);
    ack = m_busy[i] && (cyc == m_g[i] + ac[i] + 1);
    e_bus = acc ? {m_addr[i], (m_we[i] ? m_wdata[i] : 8'h00), m_we[i], !m_we[i],
                   (m_addr[i] >= 16'h8000), (m_addr[i] < 16'h8000)} : 28'h0;
    e_cpu  = (ack && !m_owner[i]) ? {1'b1, m_rd[i]} : 9'h000;
    e_host = (ack &&  m_owner[i]) ? {1'b1, m_rd[i]} : 9'h000;
    chk($sformatf("ac%0d_bus@%0d", ac[i], cyc), {ma, mw, wr, rd, rame, rome}, e_bus);
    chk($sformatf("ac%0d_cpu@%0d", ac[i], cyc), {ca, cr}, e_cpu);
    chk($sformatf("ac%0d_host@%0d", ac[i], cyc), {ha, hr}, e_host);
    chk($sformatf("ac%0d_wait@%0d", ac[i], cyc), wc, m_wait[i]);
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int gr;
      bit idle;
      bit stall;
      if (!reset) begin
        m_busy[i] = 1'b0;
        m_last[i] = 1'b1;
        m_wait[i] = 0;
      end else begin
        idle = !m_busy[i];
        gr   = -1;
        if (idle) begin
          if (host_lock)              gr = host_req ? 1 : -1;
          else if (cpu_req && host_req) gr = m_last[i] ? 0 : 1;
          else if (cpu_req)           gr = 0;
          else if (host_req)          gr = 1;
        end
        stall = cpu_req && (idle ? (gr != 0) : m_owner[i]);
        if (stall && m_wait[i] < 65535) m_wait[i]++;
        if (m_busy[i] && cyc == m_g[i] + ac[i]) m_rd[i] = m_we[i] ? 8'h00 : mem_rdata;
        if (m_busy[i] && cyc == m_g[i] + ac[i] + 1) m_busy[i] = 1'b0;
        if (gr == 0) begin
          m_busy[i] = 1'b1; m_g[i] = cyc; m_owner[i] = 1'b0; m_last[i] = 1'b0;
          m_we[i] = cpu_we; m_addr[i] = cpu_addr; m_wdata[i] = cpu_wdata;
        end else if (gr == 1) begin
          m_busy[i] = 1'b1; m_g[i] = cyc; m_owner[i] = 1'b1; m_last[i] = 1'b1;
          m_we[i] = host_we; m_addr[i] = host_addr; m_wdata[i] = host_wdata;
        end
      end
    end
  endtask

  task automatic step();
    check_dut(0, d1_cpu_rdata, d1_cpu_ack, d1_host_rdata, d1_host_ack, d1_mem_address,
              d1_mem_wdata, d1_wr_en, d1_rd_en, d1_ram_enable, d1_rom_enable, d1_cpu_wait_count);
    check_dut(1, d3_cpu_rdata, d3_cpu_ack, d3_host_rdata, d3_host_ack, d3_mem_address,
              d3_mem_wdata, d3_wr_en, d3_rd_en, d3_ram_enable, d3_rom_enable, d3_cpu_wait_count);
    model_edge();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0; host_wdata = 8'h0;
    host_lock = 1'b0; mem_rdata = 8'h00;
    @(posedge clock);
    #1;
    model_init();
    step();
    step();

    // CPU read from ROM
    reset = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h77; mem_rdata = 8'hA5;
    step();
    cpu_req = 1'b0;
    chk("a_rom_rd", {d1_rom_enable, d1_rd_en, d1_mem_address}, {2'b11, 16'h0010});
    chk("a_wait_zero", d1_cpu_wait_count, 0);
    step();
    chk("a_ack", {d1_cpu_ack, d1_cpu_rdata}, {1'b1, 8'hA5});
    repeat (6) step();

    // Host write to RAM
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h8003; host_wdata = 8'h3C;
    step();
    host_req = 1'b0;
    chk("b_ram_wr", {d1_ram_enable, d1_wr_en, d1_mem_wdata}, {2'b11, 8'h3C});
    step();
    chk("b_ack", {d1_host_ack, d1_host_rdata}, {1'b1, 8'h00});
    repeat (6) step();

    // Both requesting continuously: round-robin alternation
    reset = 1'b0;
    step();
    reset = 1'b1; cpu_req = 1'b1; host_req = 1'b1; cpu_we = 1'b0; host_we = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 2 || k == 8) chk($sformatf("c_cpu_ack_t%0d", k), d1_cpu_ack, 1);
      if (k == 5)           chk("c_host_ack_t5", d1_host_ack, 1);
    end

    // Host lock starves the CPU, release lets it in
    reset = 1'b0;
    step();
    reset = 1'b1; host_lock = 1'b1;
    repeat (9) step();
    chk("d_wait9", d1_cpu_wait_count, 9);
    host_lock = 1'b0;
    step();
    step();
    chk("d_cpu_after_lock", d1_cpu_ack, 1);

    // Reset in the second ACCESS cycle of the 3-cycle instance
    reset = 1'b0;
    step();
    reset = 1'b1; cpu_req = 1'b1; host_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0020;
    mem_rdata = 8'h5A;
    step();
    step();
    reset = 1'b0;
    step();
    chk("e_strobes_off", {d3_rd_en, d3_wr_en, d3_rom_enable, d3_ram_enable, d3_cpu_ack}, 0);
    reset = 1'b1;
    step();
    cpu_req = 1'b0;
    repeat (3) step();
    chk("e_fresh_ack", {d3_cpu_ack, d3_cpu_rdata}, {1'b1, 8'h5A});

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      reset      = ($urandom_range(0, 49) != 0);
      cpu_req    = ($urandom_range(0, 9) < 6);
      cpu_we     = 1'($urandom_range(0, 1));
      cpu_addr   = 16'($urandom);
      cpu_wdata  = 8'($urandom);
      host_req   = ($urandom_range(0, 9) < 5);
      host_we    = 1'($urandom_range(0, 1));
      host_addr  = 16'($urandom);
      host_wdata = 8'($urandom);
      host_lock  = ($urandom_range(0, 9) == 0);
      mem_rdata  = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
